fft_frame_arbiter: RTL and testbench

Shares the single frequency-raise datapath between the two FFT output streams (fft1, fft2). It grants the datapath to one source for a whole frame, from the first valid beat through the beat carrying fin, using round-robin between frames. It drives one registered output stream with backpressure, and tags that stream with the frame's frequency index and source ID. It sits between the two FFT engines and the raise stage.

---
 rtl/fft_frame_arbiter.sv | 154 +++++++++++++++
 tb/tb_fft_frame_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: frame-granular round-robin arbiter that shares one output
// stream between two FFT sources, tagging each frame with its frequency index
// and source ID, and force-terminating frames that reach MAX_BEATS beats.
module fft_frame_arbiter #(
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned FREQ_W    = 6,
   parameter int unsigned MAX_BEATS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fft1_valid,
   input  logic              fft1_fin,
   input  logic [DATA_W-1:0] fft1_data,
   input  logic [FREQ_W-1:0] freq1,
   output logic              fft1_ready,
   input  logic              fft2_valid,
   input  logic              fft2_fin,
   input  logic [DATA_W-1:0] fft2_data,
   input  logic [FREQ_W-1:0] freq2,
   output logic              fft2_ready,
   output logic              arb_valid,
   output logic              arb_fin,
   output logic [DATA_W-1:0] arb_data,
   output logic [FREQ_W-1:0] arb_freq,
   output logic              arb_src,
   input  logic              arb_ready,
   output logic              err_overrun
);

   localparam int unsigned CNT_W = $clog2(MAX_BEATS) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT1 = 2'd1,
      ST_GRANT2 = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                last_q, last_d;          // 1 = fft2 served last
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                arb_valid_q, arb_valid_d;
   logic                arb_fin_q, arb_fin_d;
   logic [DATA_W-1:0]   arb_data_q, arb_data_d;
   logic [FREQ_W-1:0]   arb_freq_q, arb_freq_d;
   logic                arb_src_q, arb_src_d;
   logic                err_q, err_d;

   logic                out_free;
   logic                sel_src;
   logic                sel_fin;
   logic [DATA_W-1:0]   sel_data;
   logic [FREQ_W-1:0]   sel_freq;
   logic                xfer;
   logic                at_max;
   logic                overrun;
   logic                frame_end;

   // Output register can take a beat when empty or being drained this cycle.
   assign out_free   = ~arb_valid_q | arb_ready;
   assign fft1_ready = (state_q == ST_GRANT1) & out_free;
   assign fft2_ready = (state_q == ST_GRANT2) & out_free;

   // Granted-source mux and transfer qualification.
   assign sel_src   = (state_q == ST_GRANT2);
   assign sel_fin   = sel_src ? fft2_fin  : fft1_fin;
   assign sel_data  = sel_src ? fft2_data : fft1_data;
   assign sel_freq  = sel_src ? freq2     : freq1;
   assign xfer      = (fft1_valid & fft1_ready) | (fft2_valid & fft2_ready);
   assign at_max    = (cnt_q == CNT_W'(MAX_BEATS - 1));
   assign overrun   = xfer & ~sel_fin & at_max;
   assign frame_end = xfer & (sel_fin | at_max);

   assign arb_valid   = arb_valid_q;
   assign arb_fin     = arb_fin_q;
   assign arb_data    = arb_data_q;
   assign arb_freq    = arb_freq_q;
   assign arb_src     = arb_src_q;
   assign err_overrun = err_q;

   // Next-state: arbitration in IDLE, frame tracking while granted, output register load/drain.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      arb_valid_d = arb_valid_q;
      arb_fin_d   = arb_fin_q;
      arb_data_d  = arb_data_q;
      arb_freq_d  = arb_freq_q;
      arb_src_d   = arb_src_q;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fft1_valid && fft2_valid) begin
               state_d = last_q ? ST_GRANT1 : ST_GRANT2;
            end else if (fft1_valid) begin
               state_d = ST_GRANT1;
            end else if (fft2_valid) begin
               state_d = ST_GRANT2;
            end
         end
         ST_GRANT1, ST_GRANT2: begin
            if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (frame_end) begin
               state_d = ST_IDLE;
               last_d  = sel_src;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (xfer) begin
         arb_valid_d = 1'b1;
         arb_data_d  = sel_data;
         arb_fin_d   = sel_fin | overrun;
         arb_src_d   = sel_src;
         err_d       = overrun;
         if (cnt_q == '0) begin
            arb_freq_d = sel_freq;
         end
      end else if (arb_ready) begin
         arb_valid_d = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         cnt_q       <= '0;
         arb_valid_q <= 1'b0;
         arb_fin_q   <= 1'b0;
         arb_data_q  <= '0;
         arb_freq_q  <= '0;
         arb_src_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         arb_valid_q <= arb_valid_d;
         arb_fin_q   <= arb_fin_d;
         arb_data_q  <= arb_data_d;
         arb_freq_q  <= arb_freq_d;
         arb_src_q   <= arb_src_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: sources replay beat queues, a frame-level
// round-robin model predicts the output beat sequence, and a monitor checks
// order, tagging, hold-under-backpressure, overrun pulses and latency.
module tb_fft_frame_arbiter;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned FREQ_W    = 6;
   localparam int unsigned MAX_BEATS = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              fft1_valid, fft1_fin, fft1_ready;
   logic [DATA_W-1:0] fft1_data;
   logic [FREQ_W-1:0] freq1;
   logic              fft2_valid, fft2_fin, fft2_ready;
   logic [DATA_W-1:0] fft2_data;
   logic [FREQ_W-1:0] freq2;
   logic              arb_valid, arb_fin, arb_src, arb_ready, err_overrun;
   logic [DATA_W-1:0] arb_data;
   logic [FREQ_W-1:0] arb_freq;

   always #5 clk = ~clk;

   fft_frame_arbiter #(.DATA_W(DATA_W), .FREQ_W(FREQ_W), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .rst(rst),
      .fft1_valid(fft1_valid), .fft1_fin(fft1_fin), .fft1_data(fft1_data),
      .freq1(freq1), .fft1_ready(fft1_ready),
      .fft2_valid(fft2_valid), .fft2_fin(fft2_fin), .fft2_data(fft2_data),
      .freq2(freq2), .fft2_ready(fft2_ready),
      .arb_valid(arb_valid), .arb_fin(arb_fin), .arb_data(arb_data),
      .arb_freq(arb_freq), .arb_src(arb_src), .arb_ready(arb_ready),
      .err_overrun(err_overrun)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              fin;
      logic [FREQ_W-1:0] freq;
   } beat_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              fin;
      logic [FREQ_W-1:0] freq;
      logic              src;
      logic              ovr;
   } out_t;

   beat_t q1[$];
   beat_t q2[$];
   out_t  expq[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    last_src = 1;
   int    bp_pct = 0;
   int    force_stall = 0;
   int    samp_idx = 0;
   int    first_v = -1;
   int    last_v = -1;
   bit    hold_pend = 1'b0;
   out_t  held;

   // Single comparison point for the whole bench.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic beat_t mk(input int d, input bit f, input int fr);
      beat_t b;
      b.data = DATA_W'(d);
      b.fin  = f;
      b.freq = FREQ_W'(fr);
      return b;
   endfunction

   // Frame-level reference: whole frames, round-robin when both sources have data.
   function automatic void plan_phase();
      int i1 = 0;
      int i2 = 0;
      int s;
      int cnt;
      bit done;
      logic [FREQ_W-1:0] f;
      beat_t b;
      out_t o;
      f = '0;
      while (i1 < q1.size() || i2 < q2.size()) begin
         if (i1 < q1.size() && i2 < q2.size()) s = (last_src == 0) ? 1 : 0;
         else s = (i1 < q1.size()) ? 0 : 1;
         cnt  = 0;
         done = 1'b0;
         while (!done) begin
            if (s == 0) begin
               if (i1 >= q1.size()) break;
               b = q1[i1]; i1++;
            end else begin
               if (i2 >= q2.size()) break;
               b = q2[i2]; i2++;
            end
            if (cnt == 0) f = b.freq;
            cnt++;
            o.data = b.data;
            o.ovr  = (cnt == int'(MAX_BEATS)) && !b.fin;
            o.fin  = b.fin || o.ovr;
            o.freq = f;
            o.src  = 1'(s);
            expq.push_back(o);
            done = o.fin;
         end
         last_src = s;
      end
   endfunction

   function automatic void add_frames(input int src, input int nfr);
      int len;
      for (int fr = 0; fr < nfr; fr++) begin
         len = int'($urandom_range(1, 6));
         for (int k = 0; k < len; k++) begin
            if (src == 0) q1.push_back(mk(int'($urandom), k == len - 1, int'($urandom)));
            else          q2.push_back(mk(int'($urandom), k == len - 1, int'($urandom)));
         end
      end
   endfunction

   function automatic void drive_sources();
      if (q1.size() > 0) begin
         fft1_valid = 1'b1; fft1_data = q1[0].data; fft1_fin = q1[0].fin; freq1 = q1[0].freq;
      end else begin
         fft1_valid = 1'b0; fft1_data = DATA_W'($urandom); fft1_fin = 1'($urandom); freq1 = FREQ_W'($urandom);
      end
      if (q2.size() > 0) begin
         fft2_valid = 1'b1; fft2_data = q2[0].data; fft2_fin = q2[0].fin; freq2 = q2[0].freq;
      end else begin
         fft2_valid = 1'b0; fft2_data = DATA_W'($urandom); fft2_fin = 1'($urandom); freq2 = FREQ_W'($urandom);
      end
   endfunction

   function automatic void drive_ready();
      if (force_stall > 0) begin
         arb_ready = 1'b0;
         force_stall--;
      end else begin
         arb_ready = (int'($urandom_range(99)) >= bp_pct);
      end
   endfunction

   // Output monitor, sampled at the falling edge.
   task automatic monitor();
      out_t cur;
      out_t e;
      bit   new_beat;
      cur.data = arb_data; cur.fin = arb_fin; cur.freq = arb_freq;
      cur.src  = arb_src;  cur.ovr = err_overrun;
      chk("ready_excl", 32'(fft1_ready && fft2_ready), 32'd0);
      if (arb_valid && !arb_ready) chk("ready_bp", 32'(fft1_ready || fft2_ready), 32'd0);
      if (hold_pend) begin
         chk("hold_valid", 32'(arb_valid), 32'd1);
         chk("hold_data", 32'(arb_data), 32'(held.data));
         chk("hold_fin", 32'(arb_fin), 32'(held.fin));
         chk("hold_freq", 32'(arb_freq), 32'(held.freq));
         chk("hold_src", 32'(arb_src), 32'(held.src));
      end
      new_beat = arb_valid && !hold_pend;
      if (arb_valid) begin
         if (first_v < 0) first_v = samp_idx;
         last_v = samp_idx;
         if (expq.size() == 0) begin
            chk("extra_beat", 32'(arb_valid), 32'd0);
         end else begin
            e = expq[0];
            if (new_beat) begin
               chk("data", 32'(arb_data), 32'(e.data));
               chk("fin", 32'(arb_fin), 32'(e.fin));
               chk("freq", 32'(arb_freq), 32'(e.freq));
               chk("src", 32'(arb_src), 32'(e.src));
            end
            chk("err_overrun", 32'(err_overrun), new_beat ? 32'(e.ovr) : 32'd0);
            if (arb_ready) expq.delete(0);
         end
      end else begin
         chk("err_idle", 32'(err_overrun), 32'd0);
      end
      hold_pend = arb_valid && !arb_ready;
      held      = cur;
      samp_idx++;
   endtask

   // One clock: sample at negedge, then update sources/ready just after posedge.
   task automatic step();
      bit hs1, hs2;
      @(negedge clk);
      hs1 = fft1_valid && fft1_ready;
      hs2 = fft2_valid && fft2_ready;
      if (!rst) monitor();
      @(posedge clk);
      #1;
      if (hs1 && q1.size() > 0) q1.delete(0);
      if (hs2 && q2.size() > 0) q2.delete(0);
      drive_sources();
      drive_ready();
   endtask

   task automatic load();
      plan_phase();
      samp_idx = 0;
      first_v  = -1;
      last_v   = -1;
      drive_sources();
   endtask

   task automatic run_phase(input string name);
      int guard = 0;
      while ((expq.size() > 0 || q1.size() > 0 || q2.size() > 0) && guard < 500) begin
         step();
         guard++;
      end
      chk({"drain_", name}, 32'(expq.size() + q1.size() + q2.size()), 32'd0);
      repeat (2) step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(arb_valid), 32'd0);
      chk({tag, "_fin"}, 32'(arb_fin), 32'd0);
      chk({tag, "_data"}, 32'(arb_data), 32'd0);
      chk({tag, "_freq"}, 32'(arb_freq), 32'd0);
      chk({tag, "_src"}, 32'(arb_src), 32'd0);
      chk({tag, "_err"}, 32'(err_overrun), 32'd0);
      chk({tag, "_rdy1"}, 32'(fft1_ready), 32'd0);
      chk({tag, "_rdy2"}, 32'(fft2_ready), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int guard;
      rst = 1'b1;
      arb_ready = 1'b1;
      drive_sources();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single 4-beat frame, no backpressure: latency and throughput.
      bp_pct = 0;
      for (int k = 0; k < 4; k++) q1.push_back(mk(k + 1, k == 3, 5));
      load();
      run_phase("p1");
      chk("p1_first_valid_cycle", 32'(first_v), 32'd2);
      chk("p1_last_valid_cycle", 32'(last_v), 32'd5);

      // Both sources request together, twice: round-robin across frames.
      for (int r = 0; r < 2; r++) begin
         q1.push_back(mk(16'h11, 1'b0, 3)); q1.push_back(mk(16'h12, 1'b1, 3));
         q2.push_back(mk(16'h21, 1'b0, 9)); q2.push_back(mk(16'h22, 1'b1, 9));
         load();
         run_phase("p2");
      end

      // Three-cycle downstream stall mid-frame.
      for (int k = 0; k < 6; k++) q1.push_back(mk(16'h31 + k, k == 5, 2));
      load();
      step(); step(); step();
      force_stall = 3;
      run_phase("p3");

      // Overrun: six beats with fin only on the sixth.
      for (int k = 0; k < 6; k++) q2.push_back(mk(16'h41 + k, k == 5, 17));
      load();
      run_phase("p4");

      // Frequency index changes after the first beat.
      q1.push_back(mk(16'h51, 1'b0, 5));
      for (int k = 1; k < 4; k++) q1.push_back(mk(16'h51 + k, k == 3, 7));
      load();
      run_phase("p5");

      // Reset in the middle of a frame, then a fresh frame.
      for (int k = 0; k < 4; k++) q2.push_back(mk(16'hA1 + k, k == 3, 12));
      load();
      guard = 0;
      while (q2.size() > 2 && guard < 50) begin step(); guard++; end
      chk("p6_beat2_accepted", 32'(q2.size()), 32'd2);
      rst = 1'b1;
      q1.delete(); q2.delete(); expq.delete();
      drive_sources();
      step();
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold_pend = 1'b0;
      last_src = 1;
      for (int k = 0; k < 3; k++) q1.push_back(mk(16'hB1 + k, k == 2, 33));
      load();
      run_phase("p6");

      // Randomized phases with random backpressure and frame lengths.
      for (int p = 0; p < 40; p++) begin
         bp_pct = int'($urandom_range(0, 70));
         add_frames(0, int'($urandom_range(0, 3)));
         add_frames(1, int'($urandom_range(0, 3)));
         load();
         run_phase("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
